// File: rtl/fp_approx_pkg.sv
// Shared types and helpers for the approximate floating-point multiplier.
//   fp_class_t  : operand classification produced in stage 1
//   acc_mode_t  : per-operation accuracy level (0 = most accurate)
//   FLAG_*      : bit positions inside the 3-bit {invalid, overflow, underflow} flags
//   fp_bias     : exponent bias for a given exponent width
//   fp_qnan     : canonical quiet NaN {0, all-ones exponent, 1, zeros}, zero-extended
package fp_approx_pkg;

  typedef enum logic [1:0] {
    FP_ZERO,
    FP_NORM,
    FP_INF,
    FP_NAN
  } fp_class_t;

  typedef logic [1:0] acc_mode_t;

  localparam int FLAG_INVALID   = 2;
  localparam int FLAG_OVERFLOW  = 1;
  localparam int FLAG_UNDERFLOW = 0;

  function automatic int fp_bias(input int exp_w);
    return (1 << (exp_w - 1)) - 1;
  endfunction

  // Returned wide so any exponent/mantissa combination fits; callers cast
  // down to their word width.
  function automatic logic [127:0] fp_qnan(input int exp_w, input int man_w);
    logic [127:0] v;
    v = '0;
    for (int i = 0; i < exp_w; i++) begin
      v[man_w + i] = 1'b1;
    end
    v[man_w - 1] = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/fp_mant_approx_mul.sv
// Stage-2 mantissa datapath of the approximate multiplier: zeroes the low
// acc_mode*TRUNC_STEP bits of each stored mantissa, restores the hidden one
// and forms the exact (2*MAN_W+2)-bit product. Purely combinational.
// Ports:
//   man_x, man_y : stored mantissa fields (hidden bit not included)
//   acc_mode     : accuracy level, 0 keeps every mantissa bit
//   prod         : exact product of {1, man_x'} and {1, man_y'}
module fp_mant_approx_mul
  import fp_approx_pkg::*;
#(
  parameter int MAN_W      = 23,
  parameter int TRUNC_STEP = 4
) (
  input  logic [MAN_W-1:0]   man_x,
  input  logic [MAN_W-1:0]   man_y,
  input  acc_mode_t          acc_mode,
  output logic [2*MAN_W+1:0] prod
);

  logic [MAN_W-1:0]   keep_mask;
  logic [2*MAN_W+1:0] op_x;
  logic [2*MAN_W+1:0] op_y;

  // Mask clears the bits discarded at the requested accuracy level.
  always_comb begin
    keep_mask = '1;
    for (int i = 0; i < MAN_W; i++) begin
      if (i < int'(acc_mode) * TRUNC_STEP) begin
        keep_mask[i] = 1'b0;
      end
    end
  end

  assign op_x = {{(MAN_W+1){1'b0}}, 1'b1, man_x & keep_mask};
  assign op_y = {{(MAN_W+1){1'b0}}, 1'b1, man_y & keep_mask};
  assign prod = op_x * op_y;

endmodule

// File: rtl/fp_mul_approx_pipe.sv
// Three-stage pipelined approximate floating-point multiplier with a
// valid/ready stream on both sides.
//   S1: classify operands, sign, biased exponent sum
//   S2: mode-dependent mantissa truncation and exact multiply
//   S3: normalize, (optionally) round, special values, pack and flag
// Optional feature macro: ROUND_NEAREST_EN. When defined, S3 rounds to
// nearest-even; otherwise the mantissa is truncated toward zero.
// Ports:
//   clk, rst_n          : clock (rising edge), async active-low reset
//   in_valid, in_ready  : input handshake
//   x_in, y_in          : operands {sign, exp, man}
//   acc_mode            : accuracy level captured with the operands
//   out_valid, out_ready: output handshake
//   result, flags       : product and {invalid, overflow, underflow}
module fp_mul_approx_pipe
  import fp_approx_pkg::*;
#(
  parameter int EXP_W      = 8,
  parameter int MAN_W      = 23,
  parameter int TRUNC_STEP = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [EXP_W+MAN_W:0]     x_in,
  input  logic [EXP_W+MAN_W:0]     y_in,
  input  acc_mode_t                acc_mode,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [EXP_W+MAN_W:0]     result,
  output logic [2:0]               flags
);

  localparam int W    = 1 + EXP_W + MAN_W;
  localparam int EW   = EXP_W + 2;
  localparam int PW   = 2 * MAN_W + 2;
  localparam int BIAS = fp_bias(EXP_W);

  localparam logic [W-1:0]          QNAN     = W'(fp_qnan(EXP_W, MAN_W));
  localparam logic [EXP_W-1:0]      EXP_ONES = '1;
  localparam logic signed [EW-1:0]  E_BIAS   = EW'(BIAS);
  localparam logic signed [EW-1:0]  E_MAX    = EW'((1 << EXP_W) - 1);
  localparam logic signed [EW-1:0]  E_ONE    = EW'(1);
  localparam logic signed [EW-1:0]  E_ZERO   = '0;

  // Pipeline control
  logic v1, v2, v3;
  logic adv1, adv2, adv3;

  // Stage registers
  logic                    s1_sign;
  fp_class_t               s1_cls_x, s1_cls_y;
  logic signed [EW-1:0]    s1_exp;
  logic [MAN_W-1:0]        s1_man_x, s1_man_y;
  acc_mode_t               s1_mode;

  logic                    s2_sign;
  fp_class_t               s2_cls_x, s2_cls_y;
  logic signed [EW-1:0]    s2_exp;
  logic [PW-1:0]           s2_prod;

  logic [W-1:0]            s3_result;
  logic [2:0]              s3_flags;

  // Operand fields
  logic                    sx, sy;
  logic [EXP_W-1:0]        ex, ey;
  logic [MAN_W-1:0]        mx, my;
  logic signed [EW-1:0]    exp_sum;

  logic [PW-1:0]           mant_prod;

  logic [MAN_W-1:0]        man_norm, man_final;
  logic signed [EW-1:0]    exp_norm, exp_final;
  logic                    is_nan, is_inf, is_zero;
  logic [W-1:0]            res_next;
  logic [2:0]              flags_next;

  function automatic fp_class_t classify(input logic [EXP_W-1:0] e,
                                         input logic [MAN_W-1:0] m);
    if (e == '0) begin
      return FP_ZERO;
    end else if (e == EXP_ONES) begin
      return (m == '0) ? FP_INF : FP_NAN;
    end else begin
      return FP_NORM;
    end
  endfunction

  // A stage may load when it is empty or its contents move on this cycle.
  assign adv3      = !v3 || out_ready;
  assign adv2      = !v2 || adv3;
  assign adv1      = !v1 || adv2;
  assign in_ready  = adv1;
  assign out_valid = v3;
  assign result    = s3_result;
  assign flags     = s3_flags;

  assign {sx, ex, mx} = x_in;
  assign {sy, ey, my} = y_in;
  assign exp_sum = $signed({2'b00, ex}) + $signed({2'b00, ey}) - E_BIAS;

  // Stage 1: capture classification, sign, exponent sum and raw mantissas.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1       <= 1'b0;
      s1_sign  <= 1'b0;
      s1_cls_x <= FP_ZERO;
      s1_cls_y <= FP_ZERO;
      s1_exp   <= '0;
      s1_man_x <= '0;
      s1_man_y <= '0;
      s1_mode  <= '0;
    end else if (adv1) begin
      v1 <= in_valid;
      if (in_valid) begin
        s1_sign  <= sx ^ sy;
        s1_cls_x <= classify(ex, mx);
        s1_cls_y <= classify(ey, my);
        s1_exp   <= exp_sum;
        s1_man_x <= mx;
        s1_man_y <= my;
        s1_mode  <= acc_mode;
      end
    end
  end

  fp_mant_approx_mul #(
    .MAN_W      (MAN_W),
    .TRUNC_STEP (TRUNC_STEP)
  ) u_mant_mul (
    .man_x    (s1_man_x),
    .man_y    (s1_man_y),
    .acc_mode (s1_mode),
    .prod     (mant_prod)
  );

  // Stage 2: register the exact truncated-mantissa product.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v2       <= 1'b0;
      s2_sign  <= 1'b0;
      s2_cls_x <= FP_ZERO;
      s2_cls_y <= FP_ZERO;
      s2_exp   <= '0;
      s2_prod  <= '0;
    end else if (adv2) begin
      v2 <= v1;
      if (v1) begin
        s2_sign  <= s1_sign;
        s2_cls_x <= s1_cls_x;
        s2_cls_y <= s1_cls_y;
        s2_exp   <= s1_exp;
        s2_prod  <= mant_prod;
      end
    end
  end

  // Product of two [1,2) values lies in [1,4); a set MSB means the value is
  // >= 2 and the exponent moves up by one.
  always_comb begin
    if (s2_prod[PW-1]) begin
      man_norm = s2_prod[PW-2 -: MAN_W];
      exp_norm = s2_exp + E_ONE;
    end else begin
      man_norm = s2_prod[PW-3 -: MAN_W];
      exp_norm = s2_exp;
    end
  end

`ifdef ROUND_NEAREST_EN
  logic           guard_bit, sticky_bit, round_up;
  logic [MAN_W:0] man_sum;

  // Round to nearest-even; a carry out of the mantissa means the value hit
  // the next power of two, so the mantissa becomes zero and exponent bumps.
  always_comb begin
    if (s2_prod[PW-1]) begin
      guard_bit  = s2_prod[MAN_W];
      sticky_bit = |s2_prod[MAN_W-1:0];
    end else begin
      guard_bit  = s2_prod[MAN_W-1];
      sticky_bit = |s2_prod[MAN_W-2:0];
    end
    round_up  = guard_bit & (sticky_bit | man_norm[0]);
    man_sum   = {1'b0, man_norm} + {{MAN_W{1'b0}}, round_up};
    man_final = man_sum[MAN_W-1:0];
    exp_final = man_sum[MAN_W] ? exp_norm + E_ONE : exp_norm;
  end
`else
  // Truncation simply drops the low product bits.
  logic prod_lsbs_unused;
  assign prod_lsbs_unused = ^s2_prod[MAN_W-1:0];
  assign man_final = man_norm;
  assign exp_final = exp_norm;
`endif

  assign is_nan  = (s2_cls_x == FP_NAN) || (s2_cls_y == FP_NAN) ||
                   ((s2_cls_x == FP_INF) && (s2_cls_y == FP_ZERO)) ||
                   ((s2_cls_x == FP_ZERO) && (s2_cls_y == FP_INF));
  assign is_inf  = (s2_cls_x == FP_INF) || (s2_cls_y == FP_INF);
  assign is_zero = (s2_cls_x == FP_ZERO) || (s2_cls_y == FP_ZERO);

  // Special values take precedence over the numeric range checks.
  always_comb begin
    res_next   = '0;
    flags_next = '0;
    if (is_nan) begin
      res_next                 = QNAN;
      flags_next[FLAG_INVALID] = 1'b1;
    end else if (is_inf) begin
      res_next = {s2_sign, EXP_ONES, {MAN_W{1'b0}}};
    end else if (is_zero) begin
      res_next = {s2_sign, {(W-1){1'b0}}};
    end else if (exp_final >= E_MAX) begin
      res_next                  = {s2_sign, EXP_ONES, {MAN_W{1'b0}}};
      flags_next[FLAG_OVERFLOW] = 1'b1;
    end else if (exp_final <= E_ZERO) begin
      res_next                   = {s2_sign, {(W-1){1'b0}}};
      flags_next[FLAG_UNDERFLOW] = 1'b1;
    end else begin
      res_next = {s2_sign, exp_final[EXP_W-1:0], man_final};
    end
  end

  // Stage 3: output register, held while the consumer stalls.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v3        <= 1'b0;
      s3_result <= '0;
      s3_flags  <= '0;
    end else if (adv3) begin
      v3 <= v2;
      if (v2) begin
        s3_result <= res_next;
        s3_flags  <= flags_next;
      end
    end
  end

endmodule

// File: doc/fp_mul_approx_pipe.md
Name: fp_mul_approx_pipe

Overview:
Parametrised, pipelined approximate floating-point multiplier. It succeeds the combinational FP32 approximate multiplier.
- Generalised to any exponent/mantissa width.
- Accuracy is selectable per operation at runtime.
- Full special-value handling and a valid/ready streaming handshake.
- Sits between operand FIFOs and the accumulator datapath in the approximate-MAC array.

Parameters:
EXP_W, 8, exponent field width (>=4)
MAN_W, 23, stored mantissa field width (>=4)
TRUNC_STEP, 4, mantissa LSBs discarded per accuracy level; 3*TRUNC_STEP must be < MAN_W

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
in_valid  in  1  operand pair valid
in_ready  out  1  block can accept operands this cycle
x_in  in  1+EXP_W+MAN_W  operand X {sign, exp, man}
y_in  in  1+EXP_W+MAN_W  operand Y
acc_mode  in  2  accuracy level for this operation (0 = most accurate), sampled with operands
out_valid  out  1  result valid
out_ready  in  1  downstream accepts result
result  out  1+EXP_W+MAN_W  product
flags  out  3  {invalid, overflow, underflow}, aligned with result

Behaviour:
- Reset (async, rst_n=0):
  - all stage-valid bits cleared.
  - out_valid=0, result=0, flags=0, in_ready=1 once rst_n is high.
  - Reset mid-operation discards every in-flight operation.
- Handshake:
  - Transfer in when in_valid & in_ready; transfer out when out_valid & out_ready.
  - in_valid/x_in/y_in/acc_mode need only be stable in the transfer cycle.
  - result/flags are held stable while out_valid & !out_ready.
- Pipeline: 3 stages, latency 3 cycles from input transfer to out_valid; throughput 1/cycle.
  - Stage k advances if it is empty or stage k+1 advances; stage 3 advances if empty or out_ready.
  - in_ready = !v1 | advance1 (combinational from out_ready).
  - No bubbles are inserted and no data is lost under any out_ready pattern.
- S1, classify and exponent:
  - exp==0 is treated as ZERO (subnormals flushed to zero).
  - exp all-ones with man==0 is INF; exp all-ones with man!=0 is NAN; otherwise NORM.
  - sign = sx^sy.
  - Exponent sum e = ex + ey - BIAS, computed signed in EXP_W+2 bits, with BIAS = 2^(EXP_W-1)-1.
- S2, mantissa:
  - Each mantissa has its low acc_mode*TRUNC_STEP bits zeroed.
  - The truncated mantissas, with hidden 1 (MAN_W+1 bits each), are multiplied exactly into a 2*MAN_W+2 bit product P.
- S3, normalize and pack:
  - If P MSB is set: take the upper MAN_W bits below the MSB and e+=1; else use the next MAN_W bits.
  - Rounding is truncation (toward zero).
  - e >= 2^EXP_W-1 gives ±INF with overflow=1.
  - e <= 0 gives ±0 with underflow=1.
- Special-value precedence (highest first):
  - Any NAN, or INF×ZERO: canonical qNaN {0, all-ones, 1, zeros}, invalid=1.
  - INF×(INF|NORM): ±INF, no flag.
  - ZERO×(ZERO|NORM): ±0, no flag.
- flags are per-result only, not sticky.

Optional Feature:
ROUND_NEAREST_EN:
- Defined: S3 rounds to nearest-even using the guard bit and an OR-reduced sticky over the discarded product bits.
  - Mantissa carry-out renormalizes (e+=1) and can trigger overflow.
  - Latency is unchanged.
- Undefined: truncation as above; no rounding logic is synthesised.

Decomposition:
- Package fp_approx_pkg holds:
  - fp_class_t enum {FP_ZERO, FP_NORM, FP_INF, FP_NAN};
  - acc_mode_t (2 bits);
  - BIAS and canonical-qNaN functions parametrised by EXP_W/MAN_W;
  - flag bit index constants.
- Sub-module fp_mant_approx_mul holds the S2 datapath: mode-dependent truncation plus the exact multiply, parametrised by MAN_W and TRUNC_STEP, purely combinational.
- Pipeline control and S1/S3 logic stay in the top module.

Test Plan:
- 0x3FC00000 × 0x40000000, mode 0 (1.5×2.0) -> result 0x40400000, flags 0, out_valid exactly 3 cycles after transfer.
- 0x3FC00000 × 0x3FC00000, mode 0 (1.5×1.5) -> 0x40100000 (normalization path, exponent +1).
- 0x3F800FFF × 0x3F800000 in mode 0 then mode 3 (TRUNC_STEP=4), back-to-back -> 0x3F800FFF, then 0x3F800000.
- Special values:
  - 0x7F7FFFFF × 0x40000000 -> 0x7F800000, overflow=1.
  - 0x7F800000 × 0x00000000 -> 0x7FC00000, invalid=1.
  - 0x00800000 × 0x00800000 -> 0x00000000, underflow=1.
  - 0x80000000 × 0x3F800000 -> 0x80000000.
- Backpressure: stream 8 ops with out_ready=0 for cycles 2-8 -> in_ready falls after 3 ops are held; all 8 results emerge in order, unchanged while stalled.
- Assert rst_n=0 for 1 cycle with 3 ops in flight -> out_valid=0 and result=0 immediately; no stale result appears after release.
